spram_bank_sched: RTL and testbench
===================================

Name: spram_bank_sched

Overview:
- Scheduler/arbiter for a FIFO built from two single-port RAM banks (even/odd interleaved entries).
- Accepts push traffic through a ready/valid handshake into a 1-entry write staging register, and pop requests through a req/ack handshake.
- Each cycle it issues at most one access per bank and resolves same-bank read/write conflicts with an anti-starvation priority FSM.
- Sits between the FIFO user logic and the two single_port_ram instances, replacing direct per-bank control.

Parameters:
- DATA_WIDTH, 8, entry width.
- ADDR_WIDTH, 3, log2 of total FIFO depth (DEPTH = 2^ADDR_WIDTH); each bank holds DEPTH/2 entries.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- wr_valid  in  1  push request
- wr_data  in  DATA_WIDTH  push data
- wr_ready  out  1  push accepted when wr_valid && wr_ready
- rd_req  in  1  pop request
- rd_ack  out  1  pop issued this cycle (combinational)
- rd_data  out  DATA_WIDTH  pop data
- rd_data_valid  out  1  rd_data valid, one cycle after rd_ack
- r_err  out  1  registered pulse: rd_req while empty
- full  out  1  committed count == DEPTH
- empty  out  1  committed count == 0
- count  out  ADDR_WIDTH+1  committed entries (staging register excluded)
- ena0, we0  out  1  bank 0 enable / write enable
- addr0  out  ADDR_WIDTH-1  bank 0 row
- din0  out  DATA_WIDTH  bank 0 write data
- dout0  in  DATA_WIDTH  bank 0 read data, one cycle after read enable
- ena1, we1, addr1, din1, dout1  same as bank 0, for bank 1

Behaviour:
- Pointers wr_ptr and rd_ptr are ADDR_WIDTH+1 bits. Bank = ptr[0]; row = ptr[ADDR_WIDTH-1:1]; the MSB is the wrap bit. count = wr_ptr - rd_ptr, modulo 2^(ADDR_WIDTH+1).
- Staging: wr_ready = !wbuf_valid && !rst. An accepted push loads wbuf_data and sets wbuf_valid. wbuf_valid clears on the cycle the buffered word is written to RAM.
- Read candidate: rd_req && !empty. Write candidate: wbuf_valid && !full.
- full, empty and count are registered values. A pop and a blocked write in the same cycle while full: the write waits until the next cycle.
- No conflict (different banks, or only one candidate): every candidate issues in the same cycle.
- Conflict (both candidates, and wr_ptr[0] == rd_ptr[0]): decided by the priority FSM.
  - RD_PRI (reset state): read issues, write stalls; next state WR_PRI.
  - WR_PRI: write issues, rd_ack=0; next state RD_PRI.
  - Any cycle in which the write issues returns the FSM to RD_PRI.
- Issued read: ena=1, we=0, addr=rd_row on bank rd_ptr[0]; rd_ack=1; rd_ptr increments. The bank select is registered; next cycle rd_data = dout of that bank and rd_data_valid=1.
- Issued write: ena=1, we=1, addr=wr_row, din=wbuf_data on bank wr_ptr[0]; wr_ptr increments.
- Idle bank: ena=0, we=0. Its addr and din hold their last value; they carry no meaning while idle.
- count updates by +1 on write, -1 on read, 0 when both occur.
- Minimum latency, push into an empty FIFO to pop data: push accepted at T, committed at T+1, rd_ack at T+2, rd_data_valid at T+3.
- Pointer wrap: row wraps modulo DEPTH/2; the MSB toggle distinguishes full from empty.
- r_err: asserted the cycle after rd_req && empty; no state change.
- Reset values: wr_ready=0 while rst is high, 1 afterwards. All other outputs are 0, except empty=1.
- Reset mid-operation: pointers and count clear, the staged word is dropped, the FSM goes to RD_PRI, and an in-flight rd_data_valid is squashed.

Optional Feature:
- Macro: SPRAM_SCHED_STATS_EN.
- When defined: adds output port conflict_cnt (16 bits). It counts every cycle in which a candidate loses arbitration, saturates at 16'hFFFF, and clears on rst.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then push 8'hA1..8'hA8 with rd_req=0 -> full=1 and count=8 after the last commit; wr_ready=0 while the 9th word waits in staging.
- From full, hold rd_req=1 for 8 cycles -> rd_data sequence A1..A8 with rd_data_valid high, each one cycle after its rd_ack; empty=1 at the end; the staged 9th word commits on the cycle after the first pop.
- Push one word with wr_ptr==rd_ptr parity while rd_req is held -> read wins, next conflicting cycle write wins (rd_ack=0), FSM alternates; no starvation beyond 1 cycle; conflict_cnt increments under SPRAM_SCHED_STATS_EN.
- Streaming push and pop every cycle with 16 words across wrap -> data order preserved, pointers wrap, count never exceeds 8.
- rd_req on empty FIFO after reset -> rd_ack=0, r_err pulses 1 cycle later, count stays 0.
- Assert rst for 1 cycle with 5 entries stored and a read in flight -> next cycle count=0, empty=1, rd_data_valid=0, wr_ready=1.

Source files
------------

// File: rtl/spram_bank_sched.sv
// Two-bank (even/odd interleaved) single-port RAM FIFO scheduler with push staging and read/write arbitration.
// Optional macro SPRAM_SCHED_STATS_EN adds the conflict_cnt output (lost-arbitration cycle counter).
module spram_bank_sched #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  rd_req,
    output logic                  rd_ack,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_data_valid,
    output logic                  r_err,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  ena0,
    output logic                  we0,
    output logic [ADDR_WIDTH-2:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0,
    output logic                  ena1,
    output logic                  we1,
    output logic [ADDR_WIDTH-2:0] addr1,
    output logic [DATA_WIDTH-1:0] din1,
`ifdef SPRAM_SCHED_STATS_EN
    output logic [15:0]           conflict_cnt,
`endif
    input  logic [DATA_WIDTH-1:0] dout1
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [0:0]    RD_PRI   = 1'b0;
    localparam logic [0:0]    WR_PRI   = 1'b1;
    localparam logic [PW-1:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [PW-1:0] ZERO_CNT = {PW{1'b0}};
    localparam logic [PW-1:0] ONE_PTR  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [PW-1:0]         wr_ptr_r, rd_ptr_r, count_r;
    logic [PW-1:0]         wr_ptr_s, rd_ptr_s, count_s;
    logic                  full_r, empty_r;
    logic                  wbuf_valid_r;
    logic [DATA_WIDTH-1:0] wbuf_data_r;
    logic [0:0]            pri_r, pri_s;
    logic                  rd_bank_r, rd_valid_r, r_err_r;
    logic [ADDR_WIDTH-2:0] addr0_r, addr1_r, addr0_s, addr1_s;
    logic [DATA_WIDTH-1:0] din0_r, din1_r, din0_s, din1_s;
    logic                  ena0_s, ena1_s, we0_s, we1_s;
    logic                  rd_cand_s, wr_cand_s, conflict_s;
    logic                  rd_issue_s, wr_issue_s, push_s;
    logic [ADDR_WIDTH-2:0] rd_row_s, wr_row_s;

    assign rd_row_s = rd_ptr_r[ADDR_WIDTH-1:1];
    assign wr_row_s = wr_ptr_r[ADDR_WIDTH-1:1];

    // Candidate qualification and same-bank arbitration; reset blocks all issue.
    always_comb begin
        rd_cand_s  = rd_req && !empty_r && !rst;
        wr_cand_s  = wbuf_valid_r && !full_r && !rst;
        conflict_s = rd_cand_s && wr_cand_s && (wr_ptr_r[0] == rd_ptr_r[0]);
        if (conflict_s) begin
            rd_issue_s = (pri_r == RD_PRI);
            wr_issue_s = (pri_r == WR_PRI);
        end else begin
            rd_issue_s = rd_cand_s;
            wr_issue_s = wr_cand_s;
        end
        push_s = wr_valid && !wbuf_valid_r && !rst;
    end

    // Priority FSM: a read win under conflict hands priority to the write; any write issue restores read priority.
    always_comb begin
        pri_s = pri_r;
        if (wr_issue_s) begin
            pri_s = RD_PRI;
        end else begin
            case (pri_r)
                RD_PRI:  pri_s = conflict_s ? WR_PRI : RD_PRI;
                WR_PRI:  pri_s = WR_PRI;
                default: pri_s = RD_PRI;
            endcase
        end
    end

    // Next pointer values; count and flags are registered from these.
    always_comb begin
        wr_ptr_s = wr_ptr_r;
        rd_ptr_s = rd_ptr_r;
        if (wr_issue_s) begin
            wr_ptr_s = wr_ptr_r + ONE_PTR;
        end else begin
            wr_ptr_s = wr_ptr_r;
        end
        if (rd_issue_s) begin
            rd_ptr_s = rd_ptr_r + ONE_PTR;
        end else begin
            rd_ptr_s = rd_ptr_r;
        end
        count_s = wr_ptr_s - rd_ptr_s;
    end

    // Per-bank port steering; an idle bank keeps its last addr/din.
    always_comb begin
        ena0_s = 1'b0; we0_s = 1'b0; addr0_s = addr0_r; din0_s = din0_r;
        ena1_s = 1'b0; we1_s = 1'b0; addr1_s = addr1_r; din1_s = din1_r;
        if (wr_issue_s && !wr_ptr_r[0]) begin
            ena0_s = 1'b1; we0_s = 1'b1; addr0_s = wr_row_s; din0_s = wbuf_data_r;
        end else if (rd_issue_s && !rd_ptr_r[0]) begin
            ena0_s = 1'b1; addr0_s = rd_row_s;
        end else begin
            ena0_s = 1'b0;
        end
        if (wr_issue_s && wr_ptr_r[0]) begin
            ena1_s = 1'b1; we1_s = 1'b1; addr1_s = wr_row_s; din1_s = wbuf_data_r;
        end else if (rd_issue_s && rd_ptr_r[0]) begin
            ena1_s = 1'b1; addr1_s = rd_row_s;
        end else begin
            ena1_s = 1'b0;
        end
    end

    // Read data comes straight from the bank selected on the issuing cycle.
    always_comb begin
        if (rd_valid_r) begin
            rd_data = rd_bank_r ? dout1 : dout0;
        end else begin
            rd_data = {DATA_WIDTH{1'b0}};
        end
    end

    // Scheduler state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r     <= ZERO_CNT;
            rd_ptr_r     <= ZERO_CNT;
            count_r      <= ZERO_CNT;
            full_r       <= 1'b0;
            empty_r      <= 1'b1;
            wbuf_valid_r <= 1'b0;
            wbuf_data_r  <= {DATA_WIDTH{1'b0}};
            pri_r        <= RD_PRI;
            rd_bank_r    <= 1'b0;
            rd_valid_r   <= 1'b0;
            r_err_r      <= 1'b0;
            addr0_r      <= {(ADDR_WIDTH-1){1'b0}};
            addr1_r      <= {(ADDR_WIDTH-1){1'b0}};
            din0_r       <= {DATA_WIDTH{1'b0}};
            din1_r       <= {DATA_WIDTH{1'b0}};
        end else begin
            wr_ptr_r   <= wr_ptr_s;
            rd_ptr_r   <= rd_ptr_s;
            count_r    <= count_s;
            full_r     <= (count_s == FULL_CNT);
            empty_r    <= (count_s == ZERO_CNT);
            pri_r      <= pri_s;
            rd_valid_r <= rd_issue_s;
            r_err_r    <= rd_req && empty_r;
            addr0_r    <= addr0_s;
            addr1_r    <= addr1_s;
            din0_r     <= din0_s;
            din1_r     <= din1_s;
            if (rd_issue_s) begin
                rd_bank_r <= rd_ptr_r[0];
            end else begin
                rd_bank_r <= rd_bank_r;
            end
            if (push_s) begin
                wbuf_valid_r <= 1'b1;
                wbuf_data_r  <= wr_data;
            end else if (wr_issue_s) begin
                wbuf_valid_r <= 1'b0;
            end else begin
                wbuf_valid_r <= wbuf_valid_r;
            end
        end
    end

`ifdef SPRAM_SCHED_STATS_EN
    logic [15:0] conflict_cnt_r;

    // Exactly one candidate loses in every conflict cycle; saturating count.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt_r <= 16'h0000;
        end else if (conflict_s && (conflict_cnt_r != 16'hFFFF)) begin
            conflict_cnt_r <= conflict_cnt_r + 16'h0001;
        end else begin
            conflict_cnt_r <= conflict_cnt_r;
        end
    end

    assign conflict_cnt = conflict_cnt_r;
`endif

    assign wr_ready      = !wbuf_valid_r && !rst;
    assign rd_ack        = rd_issue_s;
    assign rd_data_valid = rd_valid_r;
    assign r_err         = r_err_r;
    assign full          = full_r;
    assign empty         = empty_r;
    assign count         = count_r;
    assign ena0          = ena0_s;
    assign we0           = we0_s;
    assign addr0         = addr0_s;
    assign din0          = din0_s;
    assign ena1          = ena1_s;
    assign we1           = we1_s;
    assign addr1         = addr1_s;
    assign din1          = din1_s;

endmodule

// File: tb/tb_spram_bank_sched.sv
// Directed bench for spram_bank_sched with two behavioural single-port RAM banks attached.
module tb_spram_bank_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_req = 1'b0;
    logic       wr_ready, rd_ack, rd_data_valid, r_err, full, empty;
    logic [7:0] rd_data;
    logic [3:0] count;
    logic       ena0, we0, ena1, we1;
    logic [1:0] addr0, addr1;
    logic [7:0] din0, din1, dout0, dout1;
`ifdef SPRAM_SCHED_STATS_EN
    logic [15:0] conflict_cnt;
`endif

    logic [7:0] mem0 [0:3];
    logic [7:0] mem1 [0:3];
    int         n_checks = 0;
    int         n_errors = 0;
    int         sent, recv, cyc;
    logic [7:0] exp_b;

    always #5 clk = ~clk;

    spram_bank_sched #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .r_err(r_err), .full(full), .empty(empty), .count(count),
        .ena0(ena0), .we0(we0), .addr0(addr0), .din0(din0), .dout0(dout0),
        .ena1(ena1), .we1(we1), .addr1(addr1), .din1(din1),
`ifdef SPRAM_SCHED_STATS_EN
        .conflict_cnt(conflict_cnt),
`endif
        .dout1(dout1)
    );

    // Behavioural single-port RAMs, read data one cycle after enable.
    always @(posedge clk) begin
        if (ena0) begin
            if (we0) mem0[addr0] <= din0;
            else     dout0 <= mem0[addr0];
        end
        if (ena1) begin
            if (we1) mem1[addr1] <= din1;
            else     dout1 <= mem1[addr1];
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        int w;
        w = 0;
        while (wr_ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        chk("push_ready", 32'(wr_ready), 32'd1);
        wr_valid = 1'b1;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        #1;
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_rdv", 32'(rd_data_valid), 32'd0);
        chk("rst_rdata", 32'(rd_data), 32'd0);
        chk("rst_rerr", 32'(r_err), 32'd0);
        chk("rst_ena", 32'({ena0, ena1, we0, we1}), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_wr_ready", 32'(wr_ready), 32'd1);

        // Pop while empty
        rd_req = 1'b1;
        #1;
        chk("empty_rd_ack", 32'(rd_ack), 32'd0);
        tick();
        rd_req = 1'b0;
        chk("r_err_pulse", 32'(r_err), 32'd1);
        chk("r_err_count", 32'(count), 32'd0);
        tick();
        chk("r_err_clear", 32'(r_err), 32'd0);

        // Fill to full with a 9th word left in staging
        for (int i = 0; i < 9; i++) begin
            exp_b = 8'hA1 + 8'(i);
            push(exp_b);
        end
        #1;
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd8);
        chk("fill_wr_ready", 32'(wr_ready), 32'd0);
        chk("fill_blocked", 32'({ena0, ena1}), 32'd0);

        // Drain 8 while the staged word commits behind the first pop
        for (int i = 0; i < 8; i++) begin
            rd_req = 1'b1;
            #1;
            chk("drain_ack", 32'(rd_ack), 32'd1);
            if (i == 0) chk("drain_wr_wait", 32'({we0, we1}), 32'd0);
            if (i == 1) begin
                chk("drain_wr_commit", 32'(we0), 32'd1);
                chk("drain_wr_din", 32'(din0), 32'hA9);
            end
            tick();
            exp_b = 8'hA1 + 8'(i);
            chk("drain_rdv", 32'(rd_data_valid), 32'd1);
            chk("drain_data", 32'(rd_data), 32'(exp_b));
        end
        rd_req = 1'b0;
        chk("drain_count", 32'(count), 32'd1);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("ninth_data", 32'(rd_data), 32'hA9);
        chk("ninth_empty", 32'(empty), 32'd1);
        chk("ninth_count", 32'(count), 32'd0);
        tick();
        chk("ninth_rdv_clear", 32'(rd_data_valid), 32'd0);

        // Same-bank conflict: rd_ptr=9, wr_ptr=11 with B2 staged
        push(8'hB0);
        push(8'hB1);
        push(8'hB2);
        rd_req = 1'b1;
        #1;
        chk("cf_rd_wins", 32'(rd_ack), 32'd1);
        chk("cf_bank1", 32'({ena1, we1, ena0}), 32'b100);
        chk("cf_rd_addr", 32'(addr1), 32'd0);
        tick();
        chk("cf_data0", 32'(rd_data), 32'hB0);
        chk("cf_rd_ack2", 32'(rd_ack), 32'd1);
        chk("cf_wr_next", 32'({ena1, we1, ena0, we0}), 32'b1110);
        chk("cf_wr_din", 32'(din1), 32'hB2);
        chk("cf_wr_addr", 32'(addr1), 32'd1);
        tick();
        rd_req = 1'b0;
        chk("cf_data1", 32'(rd_data), 32'hB1);
        chk("cf_count", 32'(count), 32'd1);
`ifdef SPRAM_SCHED_STATS_EN
        chk("cf_stat", 32'(conflict_cnt), 32'd1);
`endif
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("cf_data2", 32'(rd_data), 32'hB2);
        chk("cf_empty", 32'(empty), 32'd1);

        // Streaming 16 words across pointer wrap
        sent = 0; recv = 0; cyc = 0;
        while (recv < 16 && cyc < 200) begin
            rd_req   = 1'b1;
            wr_valid = (sent < 16);
            wr_data  = 8'hC0 + 8'(sent);
            #1;
            if (wr_valid && wr_ready) sent++;
            chk("stream_cnt_max", 32'(count <= 4'd8), 32'd1);
            tick();
            cyc++;
            if (rd_data_valid) begin
                exp_b = 8'hC0 + 8'(recv);
                chk("stream_data", 32'(rd_data), 32'(exp_b));
                recv++;
            end
        end
        rd_req = 1'b0;
        wr_valid = 1'b0;
        chk("stream_done", 32'(recv), 32'd16);
        tick();
        chk("stream_empty", 32'(empty), 32'd1);

        // Reset with 5 stored and a read in flight
        for (int i = 0; i < 5; i++) begin
            exp_b = 8'hD0 + 8'(i);
            push(exp_b);
        end
        tick();
        chk("pre_rst_count", 32'(count), 32'd5);
        rd_req = 1'b1;
        #1;
        chk("pre_rst_ack", 32'(rd_ack), 32'd1);
        tick();
        rd_req = 1'b0;
        rst = 1'b1;
        #1;
        chk("inflight_rdv", 32'(rd_data_valid), 32'd1);
        chk("rst_hi_wr_ready", 32'(wr_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_rdv", 32'(rd_data_valid), 32'd0);
        chk("mid_rst_wr_ready", 32'(wr_ready), 32'd1);
`ifdef SPRAM_SCHED_STATS_EN
        chk("mid_rst_stat", 32'(conflict_cnt), 32'd0);
`endif

        // Minimum latency: accept T, commit T+1, ack T+2, data T+3
        push(8'hE0);
        rd_req = 1'b1;
        #1;
        chk("lat_t1_ack", 32'(rd_ack), 32'd0);
        tick();
        chk("lat_t2_ack", 32'(rd_ack), 32'd1);
        tick();
        rd_req = 1'b0;
        chk("lat_t3_rdv", 32'(rd_data_valid), 32'd1);
        chk("lat_t3_data", 32'(rd_data), 32'hE0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
